// File: rtl/bram_raster_reader.sv
// Row-major BRAM frame reader to a valid/ready pixel stream; first pixel 4 cycles after start, 1 pixel/cycle sustained.
// Credit prefetch into a 4-entry FWFT FIFO absorbs backpressure; RASTER_READER_COORDS_EN enables out_x/out_y/out_last_col.
module bram_raster_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int BASE_ADDR  = 0,
  parameter int ADDR_WIDTH = 12,
  localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1,
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
  input  logic                  clka,
  input  logic                  rstb,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_en,
  output logic                  bram_regce,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XW-1:0]         out_x,
  output logic [YW-1:0]         out_y,
  output logic                  out_last_col,
  output logic                  out_last
);

  localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(BASE_ADDR + NPIX - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state;

  logic [1:0]            rd_vld;
  logic [DATA_WIDTH-1:0] fifo_mem [4];
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [2:0]            fifo_cnt;
  logic                  push;
  logic                  pop;
  logic [2:0]            credit;

  assign bram_regce = 1'b1;
  assign push       = rd_vld[1];
  assign out_valid  = (fifo_cnt != 3'd0);
  assign out_data   = fifo_mem[rd_ptr];
  assign pop        = out_valid & out_ready;
  // Reads in flight plus buffered pixels never exceed the FIFO depth, so a push always has room.
  assign credit     = 3'(rd_vld[0]) + 3'(rd_vld[1]) + fifo_cnt - 3'(pop);
  assign bram_en    = !rstb && (state == ISSUE) && (credit < 3'd4);

  always_ff @(posedge clka) begin
    if (rstb) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      bram_addr <= FIRST_ADDR;
      rd_vld    <= 2'b00;
      wr_ptr    <= 2'd0;
      rd_ptr    <= 2'd0;
      fifo_cnt  <= 3'd0;
      for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
    end else begin
      done   <= 1'b0;
      rd_vld <= {rd_vld[0], bram_en};
      if (push) begin
        fifo_mem[wr_ptr] <= bram_dout;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      fifo_cnt <= fifo_cnt + 3'(push) - 3'(pop);
      case (state)
        IDLE: begin
          if (start) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            bram_addr <= FIRST_ADDR;
          end
        end
        ISSUE: begin
          if (bram_en) begin
            if (bram_addr == LAST_ADDR) state <= DRAIN;
            else bram_addr <= bram_addr + ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          if (pop && out_last) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            bram_addr <= FIRST_ADDR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clka) begin
    if (!rstb) assert (!(push && fifo_cnt == 3'd4 && !pop));
  end

`ifdef RASTER_READER_COORDS_EN
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;

  // Pop-side position of the FIFO head; wraps to (0,0) after the last pixel.
  always_ff @(posedge clka) begin
    if (rstb) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (pop) begin
      if (x_cnt == X_LAST) begin
        x_cnt <= '0;
        y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + YW'(1);
      end else begin
        x_cnt <= x_cnt + XW'(1);
      end
    end
  end

  assign out_x        = x_cnt;
  assign out_y        = y_cnt;
  assign out_last_col = (x_cnt == X_LAST);
  assign out_last     = out_last_col && (y_cnt == Y_LAST);
`else
  localparam int PW = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(NPIX - 1);
  logic [PW-1:0] pix_cnt;

  always_ff @(posedge clka) begin
    if (rstb) pix_cnt <= '0;
    else if (pop) pix_cnt <= (pix_cnt == P_LAST) ? '0 : pix_cnt + PW'(1);
  end

  assign out_x        = '0;
  assign out_y        = '0;
  assign out_last_col = 1'b0;
  assign out_last     = (pix_cnt == P_LAST);
`endif

endmodule

// File: tb/tb_bram_raster_reader.sv
// Bench for bram_raster_reader: 4x3, 64x64 and 1x1 instances, each fed by a 2-cycle BRAM model.
module tb_bram_raster_reader;
`ifdef RASTER_READER_COORDS_EN
  localparam bit COORDS = 1'b1;
`else
  localparam bit COORDS = 1'b0;
`endif
  localparam int AW = 4, AH = 3, AN = AW * AH, ABASE = 5;
  localparam int BW = 64, BH = 64, BN = BW * BH;
  localparam int CBASE = 3;

  logic clka = 1'b0;
  logic rstb = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;
  int   iss_cyc [BN];

  always #5 clka = ~clka;

  logic       a_start = 1'b0, a_ready = 1'b0;
  logic       a_busy, a_done, a_en, a_regce, a_valid, a_lc, a_last;
  logic [7:0] a_addr, a_data;
  logic [7:0] a_dout = 8'd0, a_r1 = 8'd0;
  logic [1:0] a_x, a_y;
  logic [7:0] a_mem [256];

  logic        b_start = 1'b0, b_ready = 1'b0;
  logic        b_busy, b_done, b_en, b_regce, b_valid, b_lc, b_last;
  logic [11:0] b_addr;
  logic [7:0]  b_data;
  logic [7:0]  b_dout = 8'd0, b_r1 = 8'd0;
  logic [5:0]  b_x, b_y;
  logic [7:0]  b_mem [4096];

  logic       c_start = 1'b0, c_ready = 1'b0;
  logic       c_busy, c_done, c_en, c_regce, c_valid, c_lc, c_last;
  logic [3:0] c_addr;
  logic [7:0] c_data;
  logic [7:0] c_dout = 8'd0, c_r1 = 8'd0;
  logic [0:0] c_x, c_y;
  logic [7:0] c_mem [16];

  bram_raster_reader #(.DATA_WIDTH(8), .IMG_WIDTH(AW), .IMG_HEIGHT(AH), .BASE_ADDR(ABASE), .ADDR_WIDTH(8)) u_a (
    .clka(clka), .rstb(rstb), .start(a_start), .busy(a_busy), .done(a_done),
    .bram_addr(a_addr), .bram_en(a_en), .bram_regce(a_regce), .bram_dout(a_dout),
    .out_data(a_data), .out_valid(a_valid), .out_ready(a_ready),
    .out_x(a_x), .out_y(a_y), .out_last_col(a_lc), .out_last(a_last));

  bram_raster_reader #(.DATA_WIDTH(8), .IMG_WIDTH(BW), .IMG_HEIGHT(BH), .BASE_ADDR(0), .ADDR_WIDTH(12)) u_b (
    .clka(clka), .rstb(rstb), .start(b_start), .busy(b_busy), .done(b_done),
    .bram_addr(b_addr), .bram_en(b_en), .bram_regce(b_regce), .bram_dout(b_dout),
    .out_data(b_data), .out_valid(b_valid), .out_ready(b_ready),
    .out_x(b_x), .out_y(b_y), .out_last_col(b_lc), .out_last(b_last));

  bram_raster_reader #(.DATA_WIDTH(8), .IMG_WIDTH(1), .IMG_HEIGHT(1), .BASE_ADDR(CBASE), .ADDR_WIDTH(4)) u_c (
    .clka(clka), .rstb(rstb), .start(c_start), .busy(c_busy), .done(c_done),
    .bram_addr(c_addr), .bram_en(c_en), .bram_regce(c_regce), .bram_dout(c_dout),
    .out_data(c_data), .out_valid(c_valid), .out_ready(c_ready),
    .out_x(c_x), .out_y(c_y), .out_last_col(c_lc), .out_last(c_last));

  // BRAM: address register then output register, data two cycles after the strobe.
  always @(posedge clka) begin
    if (a_en) a_r1 <= a_mem[a_addr];
    if (a_regce) a_dout <= a_r1;
    if (b_en) b_r1 <= b_mem[b_addr];
    if (b_regce) b_dout <= b_r1;
    if (c_en) c_r1 <= c_mem[c_addr];
    if (c_regce) c_dout <= c_r1;
  end

  task automatic test_reset();
    repeat (3) @(posedge clka);
    #1 rstb = 1'b0;
    @(negedge clka);
    n_chk++; if ({a_busy, a_done, a_en, a_valid} !== 4'b0) $display("FAIL reset_ctrl got=%b exp=0000", {a_busy, a_done, a_en, a_valid}); else n_pass++;
    n_chk++; if (a_addr !== 8'(ABASE)) $display("FAIL reset_addr got=%0d exp=%0d", a_addr, ABASE); else n_pass++;
    n_chk++; if (a_data !== 8'd0) $display("FAIL reset_data got=%0d exp=0", a_data); else n_pass++;
    n_chk++; if ({a_x, a_y} !== 4'd0) $display("FAIL reset_xy got=%0d/%0d exp=0/0", a_x, a_y); else n_pass++;
    n_chk++; if (a_regce !== 1'b1) $display("FAIL reset_regce got=%b exp=1", a_regce); else n_pass++;
    n_chk++; if ({b_busy, b_valid, b_en, c_busy, c_valid, c_en} !== 6'b0) $display("FAIL reset_other got=%b exp=0", {b_busy, b_valid, b_en, c_busy, c_valid, c_en}); else n_pass++;
    @(posedge clka); #1;
  endtask

  task automatic test_basic();
    int i;
    logic [1:0] ex, ey;
    a_ready = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      a_start = (k == 0);
      @(negedge clka);
      i = k - 4;
      n_chk++; if (a_valid !== (k >= 4 && k <= 15)) $display("FAIL basic_valid k=%0d got=%b", k, a_valid); else n_pass++;
      n_chk++; if (a_busy !== (k >= 1 && k <= 15)) $display("FAIL basic_busy k=%0d got=%b", k, a_busy); else n_pass++;
      n_chk++; if (a_done !== (k == 16)) $display("FAIL basic_done k=%0d got=%b", k, a_done); else n_pass++;
      n_chk++; if (a_en !== (k >= 1 && k <= 12)) $display("FAIL basic_en k=%0d got=%b", k, a_en); else n_pass++;
      if (k >= 1 && k <= 12) begin
        n_chk++; if (a_addr !== 8'(ABASE + k - 1)) $display("FAIL basic_addr k=%0d got=%0d exp=%0d", k, a_addr, ABASE + k - 1); else n_pass++;
      end
      if (k >= 4 && k <= 15) begin
        ex = COORDS ? 2'(i % AW) : 2'd0;
        ey = COORDS ? 2'(i / AW) : 2'd0;
        n_chk++; if (a_data !== 8'(i)) $display("FAIL basic_data k=%0d got=%0d exp=%0d", k, a_data, i); else n_pass++;
        n_chk++; if (a_x !== ex || a_y !== ey) $display("FAIL basic_xy k=%0d got=%0d/%0d exp=%0d/%0d", k, a_x, a_y, ex, ey); else n_pass++;
        n_chk++; if (a_lc !== (COORDS && (i % AW == AW - 1))) $display("FAIL basic_lastcol k=%0d got=%b", k, a_lc); else n_pass++;
        n_chk++; if (a_last !== (i == AN - 1)) $display("FAIL basic_last k=%0d got=%b", k, a_last); else n_pass++;
      end
      @(posedge clka); #1;
    end
    a_start = 1'b0;
  endtask

  // Credit model: a read issues while reads issued minus pixels accepted (after this cycle's pop) stays below 4.
  task automatic test_stall();
    int issued, avail, got, lastpop;
    logic rdy, exp_vld, exp_en, popn, held;
    logic [7:0] prev_d;
    issued = 0; avail = 0; got = 0; lastpop = -10; held = 1'b0; prev_d = 8'd0;
    for (int k = 0; k < 60; k++) begin
      rdy = !(k >= 6 && k <= 15);
      a_start = (k == 0);
      a_ready = rdy;
      @(negedge clka);
      while (avail < issued && iss_cyc[avail] + 3 <= k) avail++;
      exp_vld = (avail > got);
      popn = exp_vld && rdy;
      exp_en = (k >= 1) && (issued < AN) && ((issued - got - int'(popn)) < 4);
      n_chk++; if (a_valid !== exp_vld) $display("FAIL stall_valid k=%0d got=%b exp=%b", k, a_valid, exp_vld); else n_pass++;
      n_chk++; if (a_en !== exp_en) $display("FAIL stall_en k=%0d got=%b exp=%b", k, a_en, exp_en); else n_pass++;
      n_chk++; if (a_done !== (got == AN && k == lastpop + 1)) $display("FAIL stall_done k=%0d got=%b", k, a_done); else n_pass++;
      if (held && exp_vld) begin
        n_chk++; if (a_data !== prev_d) $display("FAIL stall_hold k=%0d got=%0d exp=%0d", k, a_data, prev_d); else n_pass++;
      end
      if (exp_en) begin
        n_chk++; if (a_addr !== 8'(ABASE + issued)) $display("FAIL stall_addr k=%0d got=%0d exp=%0d", k, a_addr, ABASE + issued); else n_pass++;
        iss_cyc[issued] = k;
        issued++;
      end
      if (popn) begin
        n_chk++; if (a_data !== 8'(got)) $display("FAIL stall_data k=%0d got=%0d exp=%0d", k, a_data, got); else n_pass++;
        n_chk++; if (a_last !== (got == AN - 1)) $display("FAIL stall_last k=%0d got=%b", k, a_last); else n_pass++;
        got++;
        if (got == AN) lastpop = k;
      end
      held = exp_vld && !rdy;
      prev_d = a_data;
      @(posedge clka); #1;
    end
    a_start = 1'b0;
    n_chk++; if (got != AN) $display("FAIL stall_count got=%0d exp=%0d", got, AN); else n_pass++;
  endtask

  task automatic test_double_start();
    int pops, dones;
    pops = 0; dones = 0;
    a_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      a_start = (k == 0 || k == 5);
      @(negedge clka);
      if (a_valid && a_ready) begin
        n_chk++; if (a_data !== 8'(pops)) $display("FAIL dstart_data idx=%0d got=%0d", pops, a_data); else n_pass++;
        pops++;
      end
      if (a_done) dones++;
      @(posedge clka); #1;
    end
    a_start = 1'b0;
    n_chk++; if (pops != AN) $display("FAIL dstart_pixels got=%0d exp=%0d", pops, AN); else n_pass++;
    n_chk++; if (dones != 1) $display("FAIL dstart_done got=%0d exp=1", dones); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int got;
    logic quiet;
    a_ready = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      a_start = (k == 0);
      rstb = (k == 8);
      @(posedge clka); #1;
    end
    rstb = 1'b0;
    @(negedge clka);
    n_chk++; if ({a_busy, a_valid, a_en, a_done} !== 4'b0) $display("FAIL rmid_ctrl got=%b exp=0000", {a_busy, a_valid, a_en, a_done}); else n_pass++;
    n_chk++; if (a_data !== 8'd0 || a_addr !== 8'(ABASE) || {a_x, a_y} !== 4'd0) $display("FAIL rmid_regs got=%0d/%0d/%0d/%0d", a_data, a_addr, a_x, a_y); else n_pass++;
    @(posedge clka); #1;
    quiet = 1'b1;
    repeat (6) begin
      @(negedge clka);
      if (a_valid !== 1'b0 || a_done !== 1'b0) quiet = 1'b0;
      @(posedge clka); #1;
    end
    n_chk++; if (quiet !== 1'b1) $display("FAIL rmid_late_data got=%b exp=1", quiet); else n_pass++;
    got = 0;
    for (int k = 0; k < 24; k++) begin
      a_start = (k == 0);
      @(negedge clka);
      if (k == 4) begin
        n_chk++; if (a_valid !== 1'b1 || a_data !== 8'd0) $display("FAIL rmid_first got=%b/%0d exp=1/0", a_valid, a_data); else n_pass++;
      end
      if (a_valid && a_ready) begin
        n_chk++; if (a_data !== 8'(got)) $display("FAIL rmid_data idx=%0d got=%0d", got, a_data); else n_pass++;
        got++;
      end
      @(posedge clka); #1;
    end
    a_start = 1'b0;
    n_chk++; if (got != AN) $display("FAIL rmid_count got=%0d exp=%0d", got, AN); else n_pass++;
  endtask

  task automatic test_one();
    c_ready = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      c_start = (k == 0);
      @(negedge clka);
      n_chk++; if (c_valid !== (k == 4)) $display("FAIL one_valid k=%0d got=%b", k, c_valid); else n_pass++;
      n_chk++; if (c_done !== (k == 5)) $display("FAIL one_done k=%0d got=%b", k, c_done); else n_pass++;
      n_chk++; if (c_en !== (k == 1)) $display("FAIL one_en k=%0d got=%b", k, c_en); else n_pass++;
      if (k == 1) begin
        n_chk++; if (c_addr !== 4'(CBASE)) $display("FAIL one_addr got=%0d exp=%0d", c_addr, CBASE); else n_pass++;
      end
      if (k == 4) begin
        n_chk++; if (c_data !== c_mem[CBASE]) $display("FAIL one_data got=%0d exp=%0d", c_data, c_mem[CBASE]); else n_pass++;
        n_chk++; if (c_last !== 1'b1 || c_lc !== COORDS) $display("FAIL one_flags got=%b/%b exp=1/%b", c_last, c_lc, COORDS); else n_pass++;
        n_chk++; if ({c_x, c_y} !== 2'b00) $display("FAIL one_xy got=%0d/%0d exp=0/0", c_x, c_y); else n_pass++;
      end
      @(posedge clka); #1;
    end
    c_start = 1'b0;
  endtask

  task automatic test_random();
    int issued, avail, got, lastpop;
    logic rdy, exp_vld, exp_en, popn, held, fin;
    logic [7:0] prev_d;
    logic [5:0] ex, ey;
    issued = 0; avail = 0; got = 0; lastpop = -10; held = 1'b0; prev_d = 8'd0; fin = 1'b0;
    for (int k = 0; k < 40000 && !fin; k++) begin
      rdy = ($urandom_range(0, 9) < 3);
      b_start = (k == 0);
      b_ready = rdy;
      @(negedge clka);
      while (avail < issued && iss_cyc[avail] + 3 <= k) avail++;
      exp_vld = (avail > got);
      popn = exp_vld && rdy;
      exp_en = (k >= 1) && (issued < BN) && ((issued - got - int'(popn)) < 4);
      n_chk++; if (b_valid !== exp_vld) $display("FAIL rand_valid k=%0d got=%b exp=%b", k, b_valid, exp_vld); else n_pass++;
      n_chk++; if (b_en !== exp_en) $display("FAIL rand_en k=%0d got=%b exp=%b", k, b_en, exp_en); else n_pass++;
      n_chk++; if (b_done !== (got == BN && k == lastpop + 1)) $display("FAIL rand_done k=%0d got=%b", k, b_done); else n_pass++;
      if (held && exp_vld) begin
        n_chk++; if (b_data !== prev_d) $display("FAIL rand_hold k=%0d got=%0d exp=%0d", k, b_data, prev_d); else n_pass++;
      end
      if (exp_en) begin
        n_chk++; if (b_addr !== 12'(issued)) $display("FAIL rand_addr k=%0d got=%0d exp=%0d", k, b_addr, issued); else n_pass++;
        iss_cyc[issued] = k;
        issued++;
      end
      if (popn) begin
        ex = COORDS ? 6'(got % BW) : 6'd0;
        ey = COORDS ? 6'(got / BW) : 6'd0;
        n_chk++; if (b_data !== b_mem[got]) $display("FAIL rand_data idx=%0d got=%0d exp=%0d", got, b_data, b_mem[got]); else n_pass++;
        n_chk++; if (b_x !== ex || b_y !== ey) $display("FAIL rand_xy idx=%0d got=%0d/%0d exp=%0d/%0d", got, b_x, b_y, ex, ey); else n_pass++;
        n_chk++; if (b_lc !== (COORDS && (got % BW == BW - 1))) $display("FAIL rand_lastcol idx=%0d got=%b", got, b_lc); else n_pass++;
        n_chk++; if (b_last !== (got == BN - 1)) $display("FAIL rand_last idx=%0d got=%b", got, b_last); else n_pass++;
        got++;
        if (got == BN) lastpop = k;
      end
      if (got == BN && k >= lastpop + 1) fin = 1'b1;
      held = exp_vld && !rdy;
      prev_d = b_data;
      @(posedge clka); #1;
    end
    b_start = 1'b0;
    n_chk++; if (got != BN || !fin) $display("FAIL rand_count got=%0d exp=%0d", got, BN); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) a_mem[i] = 8'd0;
    for (int i = 0; i < AN; i++) a_mem[ABASE + i] = 8'(i);
    for (int i = 0; i < BN; i++) b_mem[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) c_mem[i] = 8'($urandom);
    test_reset();
    test_basic();
    test_stall();
    test_double_start();
    test_reset_mid();
    test_one();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
